// File: rtl/rand_pulse_gen.sv
// Random one-hot pulse generator driven by a free-running 16-bit LFSR.
// Each run is a series of random gap / random channel / random width pulses.
module rand_pulse_gen #(
  parameter int WIDTH      = 10,
  parameter int MAX_GAP    = 5,
  parameter int MIN_PW     = 1,
  parameter int MAX_PW     = 3,
  parameter int NUM_PULSES = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pulse_cnt
);

  localparam int          CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int          PW_SPAN   = MAX_PW - MIN_PW + 1;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] NP        = 16'(NUM_PULSES);
  localparam bit          NP_EN     = (NUM_PULSES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_PULSE,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       gap_q;
  logic [7:0]       pw_q;
  logic [WIDTH-1:0] dout_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      cnt_q;

  logic [7:0]       gap_smp;
  logic [7:0]       pw_smp;
  logic [CW-1:0]    chan_smp;
  logic [WIDTH-1:0] onehot;
  logic [15:0]      cnt_inc;
  logic             last;
  int unsigned      g_u, c_u, w_u;

  // Zero seed would lock the LFSR, so it is replaced by the reset value
  always_comb begin
    lfsr_d = {lfsr_q[14:0],
              lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (seed_load) begin
      lfsr_d = (seed == '0) ? LFSR_INIT : seed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    g_u      = 32'(lfsr_q[7:0]) % 32'(MAX_GAP + 1);
    c_u      = 32'(lfsr_q) % 32'(WIDTH);
    w_u      = 32'(MIN_PW) + 32'(lfsr_q[15:8]) % 32'(PW_SPAN);
    gap_smp  = g_u[7:0];
    chan_smp = c_u[CW-1:0];
    pw_smp   = w_u[7:0] - 8'd1;
    onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << chan_smp;
    cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    last     = NP_EN && (cnt_inc == NP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      pw_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_q <= S_GAP;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            gap_q   <= gap_smp;
          end
        end
        S_GAP: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            dout_q  <= '0;
          end else if (gap_q == '0) begin
            state_q <= S_PULSE;
            dout_q  <= onehot;
            pw_q    <= pw_smp;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        S_PULSE: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            dout_q  <= '0;
          end else if (pw_q == '0) begin
            dout_q <= '0;
            cnt_q  <= cnt_inc;
            if (last) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_GAP;
              gap_q   <= gap_smp;
            end
          end else begin
            pw_q <= pw_q - 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          dout_q  <= '0;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_rand_pulse_gen.sv
// Bench for rand_pulse_gen: two instances checked cycle by cycle
// against a phase-level model of runs built from the LFSR sequence.
module tb_rand_pulse_gen;

  localparam logic [15:0] INIT = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_start = 0, a_stop = 0, a_sl = 0;
  logic [15:0] a_seed = '0;
  logic [9:0]  a_dout;
  logic        a_busy, a_done;
  logic [15:0] a_cnt;

  logic        b_start = 0, b_stop = 0, b_sl = 0;
  logic [15:0] b_seed = '0;
  logic [3:0]  b_dout;
  logic        b_busy, b_done;
  logic [15:0] b_cnt;

  rand_pulse_gen u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop),
    .seed_load(a_sl), .seed(a_seed), .dout(a_dout),
    .busy(a_busy), .done(a_done), .pulse_cnt(a_cnt)
  );

  rand_pulse_gen #(
    .WIDTH(4), .MAX_GAP(0), .MIN_PW(2), .MAX_PW(2), .NUM_PULSES(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop),
    .seed_load(b_sl), .seed(b_seed), .dout(b_dout),
    .busy(b_busy), .done(b_done), .pulse_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
    logic        stp;
  } ent_t;

  ent_t        exq[$];
  logic [9:0]  tr[$];
  logic [9:0]  tr1[$];
  logic [3:0]  seen;
  logic [15:0] ma, mb;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] l);
    logic fb;
    fb = ^(l & 16'hB400);
    return (l << 1) | 16'(fb);
  endfunction

  function automatic void push(input logic [31:0] d, input logic b,
                               input logic dn, input int k,
                               input logic s);
    ent_t e;
    e.d = d; e.busy = b; e.done = dn; e.cnt = 16'(k); e.stp = s;
    exq.push_back(e);
  endfunction

  // Each phase takes its random parameter from the LFSR value of the
  // cycle just before it; the LFSR steps once per cycle of the phase.
  task automatic build(input logic [15:0] l0, input int w, input int mg,
                       input int pmin, input int pmax, input int np,
                       input int stop_at);
    logic [15:0] l;
    int k, g, c, pw;
    bit fin;
    l = l0; k = 0; fin = 0;
    exq.delete();
    while (!fin) begin
      g = int'(l[7:0]) % (mg + 1);
      for (int i = 0; i <= g; i++) begin
        l = step(l);
        push(0, 1, 0, k, 0);
      end
      c  = int'(l) % w;
      pw = pmin + int'(l[15:8]) % (pmax - pmin + 1);
      for (int i = 0; i < pw && !fin; i++) begin
        l = step(l);
        if (k + 1 == stop_at) begin
          push(32'd1 << c, 1, 0, k, 1);
          push(0, 0, 0, k, 0);
          fin = 1;
        end else begin
          push(32'd1 << c, 1, 0, k, 0);
        end
      end
      if (!fin) begin
        k++;
        if (np != 0 && k == np) begin
          push(0, 0, 1, k, 0);
          push(0, 0, 0, k, 0);
          fin = 1;
        end
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    if (!rst_n) begin
      ma = INIT;
      mb = INIT;
    end else begin
      ma = a_sl ? ((a_seed == 0) ? INIT : a_seed) : step(ma);
      mb = b_sl ? ((b_seed == 0) ? INIT : b_seed) : step(mb);
    end
    @(negedge clk);
  endtask

  task automatic go(input bit sel, input int stop_at);
    ent_t        e;
    logic [63:0] act, exp;
    if (!sel) begin
      build(ma, 10, 5, 1, 3, 100, stop_at);
      a_start = 1;
    end else begin
      build(mb, 4, 0, 2, 2, 0, stop_at);
      b_start = 1;
    end
    tick;
    a_start = 0; b_start = 0;
    tr.delete();
    seen = '0;
    foreach (exq[i]) begin
      e   = exq[i];
      exp = {14'd0, e.d, e.busy, e.done, e.cnt};
      if (!sel) begin
        act = {14'd0, 32'(a_dout), a_busy, a_done, a_cnt};
        tr.push_back(a_dout);
      end else begin
        act = {14'd0, 32'(b_dout), b_busy, b_done, b_cnt};
        if (!e.stp) seen |= b_dout;
      end
      chk("cyc", act, exp);
      if (!sel) a_stop = e.stp; else b_stop = e.stp;
      if (e.busy || e.done) begin
        if (!sel) a_start = 1'($urandom_range(0, 1));
        else b_start = 1'($urandom_range(0, 1));
      end
      tick;
      a_start = 0; b_start = 0; a_stop = 0; b_stop = 0;
    end
  endtask

  task automatic load(input bit sel, input logic [15:0] s);
    if (!sel) begin a_sl = 1; a_seed = s; end
    else begin b_sl = 1; b_seed = s; end
    tick;
    a_sl = 0; b_sl = 0;
  endtask

  initial begin
    #50000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int zeros, diffs, n;
    ma = INIT; mb = INIT;
    repeat (3) @(negedge clk);
    chk("rst_a", {a_dout, a_busy, a_done, a_cnt}, '0);
    chk("rst_b", {b_dout, b_busy, b_done, b_cnt}, '0);
    chk("rst_lfsr", u_a.lfsr_q, INIT);
    rst_n = 1;
    repeat (2) tick;

    load(0, 16'h1234);
    go(0, 0);
    chk("cnt100", a_cnt, 100);
    chk("idle_busy", a_busy, 0);
    tr1 = tr;

    load(0, 16'h1234);
    go(0, 0);
    diffs = 0;
    n = (tr.size() < tr1.size()) ? tr.size() : tr1.size();
    for (int i = 0; i < n; i++) if (tr[i] !== tr1[i]) diffs++;
    chk("repeat_len", tr.size(), tr1.size());
    chk("repeat_trace", diffs, 0);

    for (int r = 0; r < 3; r++) begin
      load(0, 16'($urandom));
      repeat ($urandom_range(0, 4)) tick;
      go(0, $urandom_range(0, 100));
    end

    load(1, 16'h1234);
    go(1, 201);
    chk("chan_all", seen, 4'hF);
    load(1, 16'($urandom));
    go(1, 37);
    chk("stop_cnt", b_cnt, 36);
    chk("stop_busy", {b_dout, b_busy, b_done}, 0);

    load(0, 16'h0000);
    chk("seed0", u_a.lfsr_q, INIT);
    zeros = 0;
    for (int i = 0; i < 65535; i++) begin
      tick;
      if (u_a.lfsr_q == 16'h0000) zeros++;
    end
    chk("lockup", zeros, 0);
    chk("period", u_a.lfsr_q, INIT);

    load(0, 16'($urandom));
    a_start = 1;
    tick;
    a_start = 0;
    for (int i = 0; i < 50 && a_dout == '0; i++) tick;
    chk("pulse_seen", a_dout != '0, 1);
    #2 rst_n = 0;
    #1 chk("async_dout", {a_dout, a_busy}, 0);
    chk("async_cnt", a_cnt, 0);
    ma = INIT; mb = INIT;
    @(negedge clk);
    tick;
    rst_n = 1;
    chk("rel_lfsr", u_a.lfsr_q, INIT);
    go(0, 0);
    chk("cnt_after_rst", a_cnt, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_pulse_gen.md
RAND_PULSE_GEN -- requirements
Module: rand_pulse_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 10, number of output channels (2..32).
REQ-002 SHALL have parameter MAX_GAP, default 5, maximum idle gap in cycles before a pulse (0..255).
REQ-003 SHALL have parameter MIN_PW, default 1, minimum pulse width in cycles (1..255).
REQ-004 SHALL have parameter MAX_PW, default 3, maximum pulse width in cycles (MIN_PW..255).
REQ-005 SHALL have parameter NUM_PULSES, default 100, pulses per run; 0 = run until stop.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  begin run (level sampled per cycle).
REQ-009 SHALL have port stop  input  1  abort run.
REQ-010 SHALL have port seed_load  input  1  load LFSR from seed.
REQ-011 SHALL have port seed  input  16  LFSR seed value.
REQ-012 SHALL have port dout  output  WIDTH  one-hot pulse output, registered.
REQ-013 SHALL have port busy  output  1  high in GAP/PULSE states.
REQ-014 SHALL have port done  output  1  one-cycle strobe on run completion.
REQ-015 SHALL have port pulse_cnt  output  16  completed pulses in current/last run.

Function
REQ-016 SHALL hold a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle out of reset; seed_load overrides advance that cycle.
REQ-017 SHALL substitute 16'hACE1 when seed_load presents seed==0 (LFSR never all-zero).
REQ-018 SHALL implement FSM states IDLE, GAP, PULSE, DONE.
REQ-019 SHALL in IDLE with start=1 and stop=0: go to GAP, clear pulse_cnt, load gap counter G = lfsr[7:0] % (MAX_GAP+1).
REQ-020 SHALL stay in GAP G+1 cycles with dout=0 (counter decrements to 0, then transition).
REQ-021 SHALL on GAP->PULSE sample channel C = lfsr[15:0] % WIDTH and width W = MIN_PW + lfsr[15:8] % (MAX_PW-MIN_PW+1), from the LFSR value of that transition cycle.
REQ-022 SHALL drive dout = 1<<C for exactly W consecutive cycles in PULSE; exactly one bit set throughout.
REQ-023 SHALL on PULSE exit increment pulse_cnt (saturating at 16'hFFFF) and return dout to 0 the next cycle.
REQ-024 SHALL after a pulse go to DONE if NUM_PULSES!=0 and pulse_cnt reaches NUM_PULSES, else GAP with new G sampled.
REQ-025 SHALL in DONE assert done for one cycle, busy=0, dout=0, then go to IDLE.
REQ-026 SHALL on stop=1 in GAP or PULSE go to IDLE next cycle: dout=0, busy=0, done not asserted, pulse_cnt held.
REQ-027 SHALL ignore start while busy; stop wins over start in IDLE.
REQ-028 SHALL keep all outputs registered; busy=1 exactly in GAP and PULSE.

Reset
REQ-029 SHALL on rst_n=0, immediately and regardless of clk: state IDLE, dout=0, busy=0, done=0, pulse_cnt=0, lfsr=16'hACE1, counters 0.
REQ-030 SHALL on reset asserted mid-PULSE clear dout without waiting for a clock edge.

Verification
REQ-031 Default params, seed 16'h1234, start pulse -> exactly 100 pulses, each one-hot, width 1..3, gaps 1..6 cycles of zero, then done high 1 cycle, pulse_cnt=100, busy=0.
REQ-032 Same seed loaded twice, two runs -> cycle-identical dout traces.
REQ-033 seed_load with seed=0 -> next LFSR value 16'hACE1; no lock-up over 65535 cycles.
REQ-034 NUM_PULSES=0, stop asserted during 37th pulse -> dout=0 next cycle, busy=0, done stays 0, pulse_cnt=36.
REQ-035 MAX_GAP=0, MIN_PW=MAX_PW=2, WIDTH=4 -> every pulse exactly 2 cycles, gap exactly 1 cycle, dout in {1,2,4,8}, all four channels hit within 200 pulses.
REQ-036 rst_n low asynchronously mid-PULSE -> dout=0 same instant; start after release begins run from lfsr=16'hACE1.
